// File: rtl/collision_judge.sv
// Shot judge for the ball-launch game: tracks launches, evaluates the landing
// point against a target window, freezes the ball on a hit, and keeps scores.
// Latency: launch/landing/hit results appear one clock after the causing edge.
// Backpressure: none; inputs are strobes/levels and are sampled every clock.
//
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_refresh        one-cycle frame strobe
//   i_mouse_left     launch button (level); a rising edge is a launch
//   i_x_pos, i_y_pos signed ball screen position (13 bits)
//   i_z_neg          ball is below ground (landed)
//   o_en_collision   freeze the landed ball in the motion stage
//   o_collision_done one-cycle pulse that clears the motion stage
//   o_hit            result of the last evaluated shot
//   o_score          saturating hit count
//   o_shots          saturating launch count
//   o_busy           state machine is not idle
module collision_judge #(
  parameter int TGT_X_MIN   = -40,
  parameter int TGT_X_MAX   = 40,
  parameter int TGT_Y_MIN   = 200,
  parameter int TGT_Y_MAX   = 260,
  parameter int HOLD_FRAMES = 90
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_refresh,
  input  logic               i_mouse_left,
  input  logic signed [12:0] i_x_pos,
  input  logic signed [12:0] i_y_pos,
  input  logic               i_z_neg,
  output logic               o_en_collision,
  output logic               o_collision_done,
  output logic               o_hit,
  output logic [7:0]         o_score,
  output logic [7:0]         o_shots,
  output logic               o_busy
);

  // State encoding kept as plain constants for compatibility with older tools.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FLIGHT   = 3'd1;
  localparam logic [2:0] S_EVAL     = 3'd2;
  localparam logic [2:0] S_HIT_HOLD = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_MISS     = 3'd5;

  // Window bounds narrowed to the position width so comparisons stay signed
  // and width-matched.
  localparam logic signed [12:0] X_MIN = 13'(TGT_X_MIN);
  localparam logic signed [12:0] X_MAX = 13'(TGT_X_MAX);
  localparam logic signed [12:0] Y_MIN = 13'(TGT_Y_MIN);
  localparam logic signed [12:0] Y_MAX = 13'(TGT_Y_MAX);
  localparam logic [6:0]         HOLD_LAST = 7'(HOLD_FRAMES - 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic               mouse_q;
  logic               armed;
  logic               launch;
  logic               landed;
  logic               hit_now;
  logic               hold_last;
  logic [6:0]         hold_cnt;
  logic signed [12:0] x_lat;
  logic signed [12:0] y_lat;

  // The armed flag masks the first cycle after reset: mouse_q comes out of
  // reset low, so a button already held would otherwise look like an edge.
  assign launch = armed & i_mouse_left & ~mouse_q;

  // A landing only counts once the button is released; a held button with
  // the ball underground is still part of the launch gesture.
  assign landed = i_z_neg & ~i_mouse_left;

  assign hit_now = (x_lat >= X_MIN) && (x_lat <= X_MAX) &&
                   (y_lat >= Y_MIN) && (y_lat <= Y_MAX);

  assign hold_last = (hold_cnt == HOLD_LAST);

  assign o_busy = (state != S_IDLE);

  // Next-state logic. A launch overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        state_nxt = S_IDLE;
      end
      S_FLIGHT: begin
        if (landed) begin
          state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        state_nxt = hit_now ? S_HIT_HOLD : S_MISS;
      end
      S_HIT_HOLD: begin
        if (i_refresh && hold_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_MISS: begin
        // Wait for the motion stage to pull the ball back above ground.
        if (!i_z_neg) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (launch) begin
      state_nxt = S_FLIGHT;
    end
  end

  // State register and registered outputs that follow the next state, so
  // o_en_collision/o_collision_done line up exactly with HIT_HOLD/DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      mouse_q          <= 1'b0;
      armed            <= 1'b0;
      o_en_collision   <= 1'b0;
      o_collision_done <= 1'b0;
    end else begin
      state            <= state_nxt;
      mouse_q          <= i_mouse_left;
      armed            <= 1'b1;
      o_en_collision   <= (state_nxt == S_HIT_HOLD) || (state_nxt == S_DONE);
      o_collision_done <= (state_nxt == S_DONE);
    end
  end

  // Datapath: counters, landing latch and hit result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_cnt <= 7'd0;
      x_lat    <= 13'sd0;
      y_lat    <= 13'sd0;
      o_hit    <= 1'b0;
      o_score  <= 8'd0;
      o_shots  <= 8'd0;
    end else if (launch) begin
      // A launch also swallows a coincident refresh: the hold counter clears.
      hold_cnt <= 7'd0;
      if (o_shots != 8'hFF) begin
        o_shots <= o_shots + 8'd1;
      end
    end else begin
      case (state)
        S_FLIGHT: begin
          if (landed) begin
            x_lat <= i_x_pos;
            y_lat <= i_y_pos;
          end
        end
        S_EVAL: begin
          o_hit    <= hit_now;
          hold_cnt <= 7'd0;
          if (hit_now && (o_score != 8'hFF)) begin
            o_score <= o_score + 8'd1;
          end
        end
        S_HIT_HOLD: begin
          if (i_refresh && !hold_last) begin
            hold_cnt <= hold_cnt + 7'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
